// File: rtl/hazard_fwd_unit.sv
// Operand forwarding and load-use stall detection for the l2 stage; zero-latency combinational outputs.
// Optional stall counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_fwd_unit #(
    parameter int XLEN           = 32,
    parameter int NSTG           = 2,
    parameter int LOAD_READY_STG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_l2,
    input  logic                 we_l2,
    input  logic                 is_load_l2,
    input  logic [4:0]           rd_l2,
    input  logic [4:0]           rs1_l2,
    input  logic [4:0]           rs2_l2,
    input  logic                 use_rs1_l2,
    input  logic                 use_rs2_l2,
    input  logic [XLEN-1:0]      xrs1_l2,
    input  logic [XLEN-1:0]      xrs2_l2,
    input  logic [NSTG*XLEN-1:0] wval_fwd,
    input  logic                 hold,
    input  logic                 flush_l2,
    output logic [XLEN-1:0]      alu_a_l2,
    output logic [XLEN-1:0]      alu_b_l2,
    output logic                 stall_l2
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    logic [NSTG:1] tag_v;
    logic [NSTG:1] tag_we;
    logic [NSTG:1] tag_ld;
    logic [4:0]    tag_rd [1:NSTG];

    logic [NSTG:1] hit1;
    logic [NSTG:1] hit2;
    logic          haz1;
    logic          haz2;

    // Scan from the oldest stage down so the youngest (lowest-index) match wins,
    // which also lets a younger non-load shadow an older load.
    always_comb begin
        alu_a_l2 = xrs1_l2;
        alu_b_l2 = xrs2_l2;
        haz1     = 1'b0;
        haz2     = 1'b0;
        hit1     = '0;
        hit2     = '0;
        for (int k = NSTG; k >= 1; k--) begin
            hit1[k] = tag_v[k] && tag_we[k] && (tag_rd[k] == rs1_l2) && (rs1_l2 != 5'd0);
            hit2[k] = tag_v[k] && tag_we[k] && (tag_rd[k] == rs2_l2) && (rs2_l2 != 5'd0);
            if (hit1[k]) begin
                alu_a_l2 = wval_fwd[(k-1)*XLEN +: XLEN];
                haz1     = tag_ld[k] && (k < LOAD_READY_STG);
            end
            if (hit2[k]) begin
                alu_b_l2 = wval_fwd[(k-1)*XLEN +: XLEN];
                haz2     = tag_ld[k] && (k < LOAD_READY_STG);
            end
        end
        stall_l2 = valid_l2 && !flush_l2 && ((use_rs1_l2 && haz1) || (use_rs2_l2 && haz2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
        end else if (!hold) begin
            tag_v[1]  <= valid_l2 && !flush_l2 && !stall_l2;
            tag_we[1] <= we_l2;
            tag_ld[1] <= is_load_l2;
            tag_rd[1] <= rd_l2;
            for (int k = 2; k <= NSTG; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_we[k] <= tag_we[k-1];
                tag_ld[k] <= tag_ld[k-1];
                tag_rd[k] <= tag_rd[k-1];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_l2 && !hold) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
